// File: rtl/sprite_blit.sv
// Sprite renderer: walks one SPR_W x SPR_H sprite from an external pixel ROM and
// emits one VGA plot per opaque, on-screen pixel, with orientation, erase and clipping.
module sprite_blit #(
   parameter int SPR_W   = 8,
   parameter int SPR_H   = 14,
   parameter int ADDR_W  = 7,
   parameter int COLOR_W = 9,
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int X_MAX   = 160,
   parameter int Y_MAX   = 120
) (
   input  logic               iClock,
   input  logic               iReset,
   input  logic               iStart,
   input  logic [X_W-1:0]     iX,
   input  logic [Y_W-1:0]     iY,
   input  logic [2:0]         iDir,
   input  logic               iErase,
   input  logic [COLOR_W-1:0] iBgColour,
   output logic [ADDR_W-1:0]  oRomAddr,
   input  logic [COLOR_W:0]   iRomData,
   output logic [X_W-1:0]     oX,
   output logic [Y_W-1:0]     oY,
   output logic [COLOR_W-1:0] oColour,
   output logic               oPlot,
   output logic               oBusy,
   output logic               oDone
);

   localparam int C_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int R_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t state_reg, state_next;
   logic               drain_reg;
   logic [C_W-1:0]     col_reg;
   logic [R_W-1:0]     row_reg;
   logic [X_W-1:0]     x_reg;
   logic [Y_W-1:0]     y_reg;
   logic [2:0]         dir_reg;
   logic               erase_reg;
   logic [COLOR_W-1:0] bg_reg;

   // Stage 2 holds the screen point of the pixel whose ROM word arrives next cycle.
   logic [X_W-1:0]     x_s2_reg;
   logic [Y_W-1:0]     y_s2_reg;
   logic               vis_s2_reg;

   logic               accept;
   logic               last_pix;
   logic [C_W-1:0]     sc;
   logic [R_W-1:0]     sr;
   logic [X_W:0]       dx, x_pt;
   logic [Y_W:0]       dy, y_pt;

   assign accept   = (state_reg == IDLE) && iStart;
   assign last_pix = (col_reg == C_W'(SPR_W - 1)) && (row_reg == R_W'(SPR_H - 1));
   assign oBusy    = (state_reg == FETCH) || (state_reg == DRAIN);
   assign oDone    = (state_reg == DONE);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (iStart) state_next = FETCH;
         FETCH:   if (last_pix) state_next = DRAIN;
         DRAIN:   if (drain_reg) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Orientation transform and unwrapped screen point, one bit wider than the screen.
   always_comb begin
      sc = dir_reg[1] ? (C_W'(SPR_W - 1) - col_reg) : col_reg;
      sr = dir_reg[2] ? (R_W'(SPR_H - 1) - row_reg) : row_reg;
      if (dir_reg[0]) begin
         dx = (X_W+1)'(sr);
         dy = (Y_W+1)'(sc);
      end else begin
         dx = (X_W+1)'(sc);
         dy = (Y_W+1)'(sr);
      end
      x_pt = {1'b0, x_reg} + dx;
      y_pt = {1'b0, y_reg} + dy;
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_reg  <= IDLE;
         drain_reg  <= 1'b0;
         col_reg    <= '0;
         row_reg    <= '0;
         oRomAddr   <= '0;
         x_reg      <= '0;
         y_reg      <= '0;
         dir_reg    <= '0;
         erase_reg  <= 1'b0;
         bg_reg     <= '0;
         x_s2_reg   <= '0;
         y_s2_reg   <= '0;
         vis_s2_reg <= 1'b0;
         oX         <= '0;
         oY         <= '0;
         oColour    <= '0;
         oPlot      <= 1'b0;
      end else begin
         state_reg <= state_next;
         drain_reg <= (state_reg == DRAIN) ? ~drain_reg : 1'b0;

         if (accept) begin
            x_reg     <= iX;
            y_reg     <= iY;
            dir_reg   <= iDir;
            erase_reg <= iErase;
            bg_reg    <= iBgColour;
            col_reg   <= '0;
            row_reg   <= '0;
            oRomAddr  <= '0;
         end else if (state_reg == FETCH && !last_pix) begin
            oRomAddr <= oRomAddr + ADDR_W'(1);
            if (col_reg == C_W'(SPR_W - 1)) begin
               col_reg <= '0;
               row_reg <= row_reg + R_W'(1);
            end else begin
               col_reg <= col_reg + C_W'(1);
            end
         end

         vis_s2_reg <= (state_reg == FETCH) && (x_pt < (X_W+1)'(X_MAX))
                       && (y_pt < (Y_W+1)'(Y_MAX));
         x_s2_reg   <= x_pt[X_W-1:0];
         y_s2_reg   <= y_pt[Y_W-1:0];

         oPlot <= vis_s2_reg && iRomData[COLOR_W];
         if (vis_s2_reg) begin
            oX      <= x_s2_reg;
            oY      <= y_s2_reg;
            oColour <= erase_reg ? bg_reg : iRomData[COLOR_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_sprite_blit.sv
// Directed bench for sprite_blit: behavioural ROM with registered read, per-cycle
// capture of the VGA port, and hand-computed expectations per scenario.
module tb_sprite_blit;

   localparam int N    = 112;
   localparam int LAST = N + 4;

   logic       clk, rst, start, serase;
   logic [7:0] sx;
   logic [6:0] sy;
   logic [2:0] sdir;
   logic [8:0] sbg;
   logic [6:0] rom_addr;
   logic [9:0] rom_data;
   logic [7:0] px;
   logic [6:0] py;
   logic [8:0] pcol;
   logic       plot, busy, done;

   logic [9:0] rom_mem [0:127];

   logic       rec_plot [0:127];
   logic [7:0] rec_x    [0:127];
   logic [6:0] rec_y    [0:127];
   logic [8:0] rec_c    [0:127];
   logic       rec_busy [0:127];
   logic [6:0] rec_addr [0:127];
   int plot_count, done_count, done_at;
   int checks = 0;
   int failures = 0;

   sprite_blit dut (
      .iClock(clk), .iReset(rst), .iStart(start), .iX(sx), .iY(sy), .iDir(sdir),
      .iErase(serase), .iBgColour(sbg), .oRomAddr(rom_addr), .iRomData(rom_data),
      .oX(px), .oY(py), .oColour(pcol), .oPlot(plot), .oBusy(busy), .oDone(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   // Start one draw, scramble the inputs after accept, and record cycles 1..LAST.
   task automatic run_draw(input logic [7:0] x, input logic [6:0] y, input logic [2:0] dir,
                           input logic erase, input logic [8:0] bg);
      @(negedge clk);
      sx = x; sy = y; sdir = dir; serase = erase; sbg = bg; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; sx = ~x; sy = ~y; sdir = ~dir; serase = ~erase; sbg = ~bg;
      plot_count = 0; done_count = 0; done_at = -1;
      for (int k = 1; k <= LAST; k++) begin
         rec_plot[k] = plot; rec_x[k] = px; rec_y[k] = py; rec_c[k] = pcol;
         rec_busy[k] = busy; rec_addr[k] = rom_addr;
         if (plot) plot_count++;
         if (done) begin done_count++; done_at = k; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; sx = 8'd3; sy = 7'd4; sdir = 3'd0; serase = 1'b0; sbg = 9'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rom_addr !== 7'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
      checks++; if (px !== 8'd0 || py !== 7'd0) begin failures++; $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", px, py); end
      checks++; if (pcol !== 9'd0) begin failures++; $display("FAIL reset_colour: got %0h expected 0", pcol); end
      checks++; if ({plot, busy, done} !== 3'b000) begin failures++; $display("FAIL reset_flags: got plot/busy/done=%b expected 000", {plot, busy, done}); end
      start = 1'b0;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_default();
      int bad = 0;
      for (int a = 0; a < 128; a++) rom_mem[a] = 10'h3C0;
      run_draw(8'd10, 7'd20, 3'b000, 1'b0, 9'h0);
      for (int k = 1; k <= N; k++) if (rec_addr[k] !== 7'(k - 1)) bad++;
      for (int k = 1; k <= N + 2; k++) if (rec_busy[k] !== 1'b1) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL default_addr_busy: got %0d bad cycles expected 0", bad); end
      checks++; if (plot_count != 112) begin failures++; $display("FAIL default_count: got %0d expected 112", plot_count); end
      checks++; if (rec_plot[2] !== 1'b0 || rec_plot[3] !== 1'b1) begin failures++; $display("FAIL default_first_latency: got plot c2=%b c3=%b expected 0,1", rec_plot[2], rec_plot[3]); end
      checks++; if (rec_x[3] !== 8'd10 || rec_y[3] !== 7'd20 || rec_c[3] !== 9'h1C0) begin failures++; $display("FAIL default_pix0: got (%0d,%0d) %h expected (10,20) 1c0", rec_x[3], rec_y[3], rec_c[3]); end
      checks++; if (rec_plot[114] !== 1'b1 || rec_x[114] !== 8'd17 || rec_y[114] !== 7'd33) begin failures++; $display("FAIL default_pix111: got plot=%b (%0d,%0d) expected 1 (17,33)", rec_plot[114], rec_x[114], rec_y[114]); end
      checks++; if (done_count != 1 || done_at != 115) begin failures++; $display("FAIL default_done: got count=%0d at=%0d expected 1 at 115", done_count, done_at); end
      checks++; if (rec_busy[115] !== 1'b0 || rec_plot[115] !== 1'b0) begin failures++; $display("FAIL default_done_cycle: got busy=%b plot=%b expected 0,0", rec_busy[115], rec_plot[115]); end
   endtask

   task automatic test_transpose();
      int bad = 0;
      int maxx = 0;
      int maxy = 0;
      for (int a = 0; a < 128; a++) rom_mem[a] = {1'b1, 9'(a)};
      run_draw(8'd0, 7'd0, 3'b001, 1'b0, 9'h0);
      for (int k = 3; k <= 114; k++) begin
         if (rec_plot[k] !== 1'b1 || rec_x[k] !== 8'((k - 3) / 8) || rec_y[k] !== 7'((k - 3) % 8)
             || rec_c[k] !== 9'(k - 3)) bad++;
         if (rec_plot[k] === 1'b1) begin
            if (int'(rec_x[k]) > maxx) maxx = int'(rec_x[k]);
            if (int'(rec_y[k]) > maxy) maxy = int'(rec_y[k]);
         end
      end
      checks++; if (rec_x[16] !== 8'd1 || rec_y[16] !== 7'd5 || rec_c[16] !== 9'd13) begin failures++; $display("FAIL transpose_addr13: got (%0d,%0d) c=%0d expected (1,5) c=13", rec_x[16], rec_y[16], rec_c[16]); end
      checks++; if (maxx != 13 || maxy != 7) begin failures++; $display("FAIL transpose_bbox: got max (%0d,%0d) expected (13,7)", maxx, maxy); end
      checks++; if (bad != 0) begin failures++; $display("FAIL transpose_sweep: got %0d bad pixels expected 0", bad); end
   endtask

   task automatic test_flip_xy();
      run_draw(8'd30, 7'd40, 3'b110, 1'b0, 9'h0);
      checks++; if (rec_x[3] !== 8'd37 || rec_y[3] !== 7'd53 || rec_c[3] !== 9'd0) begin failures++; $display("FAIL flip_addr0: got (%0d,%0d) c=%0d expected (37,53) c=0", rec_x[3], rec_y[3], rec_c[3]); end
      checks++; if (rec_x[16] !== 8'd32 || rec_y[16] !== 7'd52) begin failures++; $display("FAIL flip_addr13: got (%0d,%0d) expected (32,52)", rec_x[16], rec_y[16]); end
      checks++; if (rec_x[114] !== 8'd30 || rec_y[114] !== 7'd40 || rec_c[114] !== 9'd111) begin failures++; $display("FAIL flip_addr111: got (%0d,%0d) c=%0d expected (30,40) c=111", rec_x[114], rec_y[114], rec_c[114]); end
   endtask

   task automatic test_erase();
      int bad_col = 0;
      int even_hits = 0;
      for (int a = 0; a < 128; a++) rom_mem[a] = {a[0], 9'(a)};
      run_draw(8'd50, 7'd60, 3'b000, 1'b1, 9'h000);
      for (int k = 3; k <= 114; k++) begin
         if (rec_plot[k] === 1'b1 && rec_c[k] !== 9'h000) bad_col++;
         if (rec_plot[k] === 1'b1 && ((k - 3) % 2) == 0) even_hits++;
      end
      checks++; if (plot_count != 56) begin failures++; $display("FAIL erase_count: got %0d expected 56", plot_count); end
      checks++; if (bad_col != 0) begin failures++; $display("FAIL erase_colour: got %0d non-bg plots expected 0", bad_col); end
      checks++; if (even_hits != 0) begin failures++; $display("FAIL erase_transparent: got %0d even-address plots expected 0", even_hits); end
      checks++; if (rec_plot[4] !== 1'b1 || rec_x[4] !== 8'd51 || rec_y[4] !== 7'd60) begin failures++; $display("FAIL erase_addr1: got plot=%b (%0d,%0d) expected 1 (51,60)", rec_plot[4], rec_x[4], rec_y[4]); end
   endtask

   task automatic test_clip();
      int wraps = 0;
      for (int a = 0; a < 128; a++) rom_mem[a] = 10'h3C0;
      run_draw(8'd155, 7'd115, 3'b000, 1'b0, 9'h0);
      for (int k = 1; k <= LAST; k++)
         if (rec_plot[k] === 1'b1 && (rec_x[k] < 8'd155 || rec_x[k] > 8'd159 || rec_y[k] < 7'd115 || rec_y[k] > 7'd119)) wraps++;
      checks++; if (plot_count != 25) begin failures++; $display("FAIL clip_count: got %0d expected 25", plot_count); end
      checks++; if (wraps != 0) begin failures++; $display("FAIL clip_wrap: got %0d out-of-window plots expected 0", wraps); end
      checks++; if (rec_plot[7] !== 1'b1 || rec_x[7] !== 8'd159 || rec_plot[8] !== 1'b0) begin failures++; $display("FAIL clip_x_edge: got c7=%b x=%0d c8=%b expected 1 159 0", rec_plot[7], rec_x[7], rec_plot[8]); end
      checks++; if (rec_plot[39] !== 1'b1 || rec_y[39] !== 7'd119 || rec_plot[43] !== 1'b0) begin failures++; $display("FAIL clip_y_edge: got c39=%b y=%0d c43=%b expected 1 119 0", rec_plot[39], rec_y[39], rec_plot[43]); end
      checks++; if (done_count != 1 || done_at != 115) begin failures++; $display("FAIL clip_done: got count=%0d at=%0d expected 1 at 115", done_count, done_at); end
   endtask

   task automatic test_back_to_back();
      logic done115, busy116, done116, busy117, busy166, plot166;
      logic [6:0] addr117, addr118;
      int stray = 0;
      @(negedge clk);
      sx = 8'd10; sy = 7'd20; sdir = 3'b000; serase = 1'b0; sbg = 9'h0; start = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 166; k++) begin
         if (k == 115) done115 = done;
         if (k == 116) begin busy116 = busy; done116 = done; end
         if (k == 117) begin busy117 = busy; addr117 = rom_addr; end
         if (k == 118) addr118 = rom_addr;
         if (k == 166) begin busy166 = busy; plot166 = plot; end
         if (k < 166) begin @(posedge clk); #1; end
      end
      checks++; if (done115 !== 1'b1 || busy116 !== 1'b0 || done116 !== 1'b0) begin failures++; $display("FAIL b2b_gap: got done115=%b busy116=%b done116=%b expected 1 0 0", done115, busy116, done116); end
      checks++; if (busy117 !== 1'b1 || addr117 !== 7'd0 || addr118 !== 7'd1) begin failures++; $display("FAIL b2b_restart: got busy=%b addr %0d,%0d expected 1 0,1", busy117, addr117, addr118); end
      checks++; if (busy166 !== 1'b1 || plot166 !== 1'b1) begin failures++; $display("FAIL b2b_mid: got busy=%b plot=%b expected 1 1", busy166, plot166); end
      rst = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      checks++; if ({rom_addr, px, py, pcol, plot, busy, done} !== '0) begin failures++; $display("FAIL b2b_reset_outputs: got addr=%0d x=%0d y=%0d c=%h p/b/d=%b expected all 0", rom_addr, px, py, pcol, {plot, busy, done}); end
      rst = 1'b0;
      for (int k = 0; k < 130; k++) begin
         if (plot || busy || done) stray++;
         @(posedge clk); #1;
      end
      checks++; if (stray != 0) begin failures++; $display("FAIL b2b_aborted: got %0d active cycles after reset expected 0", stray); end
      run_draw(8'd10, 7'd20, 3'b000, 1'b0, 9'h0);
      checks++; if (plot_count != 112 || done_count != 1 || done_at != 115) begin failures++; $display("FAIL b2b_after_reset: got plots=%0d done=%0d at %0d expected 112 1 115", plot_count, done_count, done_at); end
   endtask

   initial begin
      test_reset();
      test_default();
      test_transpose();
      test_flip_xy();
      test_erase();
      test_clip();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
